// File: rtl/regfile_sb_pkg.sv
// Shared constants and FSM encoding for the ID-stage register file.
package regfile_sb_pkg;

  localparam int REGNUM_ZERO = 0;
  localparam int REGNUM_RA   = 31;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Read/write/issue bus of the register file; slave = the file, master = the pipeline.
interface regfile_sb_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);
  logic              INIT_REQ;
  logic              READY;
  logic [NRD*AW-1:0] RADDR;
  logic [NRD*DW-1:0] RDATA;
  logic [NRD-1:0]    HAZARD;
  logic              ISSUE_VLD;
  logic [AW-1:0]     ISSUE_DST;
  logic              WE;
  logic [AW-1:0]     WADDR;
  logic [DW-1:0]     WDATA;

  modport slave (
    input  INIT_REQ, RADDR, ISSUE_VLD, ISSUE_DST, WE, WADDR, WDATA,
    output READY, RDATA, HAZARD
  );

  modport master (
    output INIT_REQ, RADDR, ISSUE_VLD, ISSUE_DST, WE, WADDR, WDATA,
    input  READY, RDATA, HAZARD
  );
endinterface

// File: rtl/regfile_sb_rport.sv
// One combinational read port: r0 guard, write-to-read bypass and hazard qualification.
module regfile_rport #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic          run,
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] stored,
  input  logic          pending,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          hazard
);

  logic hit;

  // A bypassed write also resolves the hazard, since the operand is now on the bus.
  assign hit = (BYPASS != 0) && we && (waddr == raddr) && (waddr != '0);

  always_comb begin
    rdata = '0;
    if (run && (raddr != '0)) begin
      rdata = hit ? wdata : stored;
    end
  end

  assign hazard = run & pending & ~hit;

endmodule

// File: rtl/regfile_sb.sv
// MIPS register file with a power-up clear sweep, issue scoreboard, bypass and r0 guard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  regfile_sb_if.slave  bus
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] IDX_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] R0 = AW'(REGNUM_ZERO);

  rf_state_t      state_q, state_d;
  logic [AW:0]    idx_q, idx_d;
  logic [DW-1:0]  mem [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic           run;
  logic           wr_en;
  logic           iss_en;

  assign run    = (state_q == RF_RUN);
  assign wr_en  = run & bus.WE & (bus.WADDR != R0);
  assign iss_en = run & bus.ISSUE_VLD & (bus.ISSUE_DST != R0);
  assign bus.READY = run;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RF_INIT;
      idx_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      RF_INIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = RF_RUN;
      end
      RF_RUN: begin
        if (bus.INIT_REQ) begin
          state_d = RF_INIT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = RF_INIT;
        idx_d   = '0;
      end
    endcase
  end

  // Set after clear so a re-issued destination stays outstanding.
  always_comb begin
    pend_d = pend_q;
    if (!run || bus.INIT_REQ) begin
      pend_d = '0;
    end else begin
      if (wr_en)  pend_d[bus.WADDR]     = 1'b0;
      if (iss_en) pend_d[bus.ISSUE_DST] = 1'b1;
    end
    pend_d[REGNUM_ZERO] = 1'b0;
  end

  // Storage is data only: the sweep, not the reset, gives it a defined value.
  always_ff @(posedge CLK) begin
    if (!run) begin
      mem[idx_q[AW-1:0]] <= '0;
    end else if (wr_en) begin
      mem[bus.WADDR] <= bus.WDATA;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rport
    logic [AW-1:0] ra;
    assign ra = bus.RADDR[i*AW +: AW];

    regfile_rport #(
      .DW     (DW),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rport (
      .run     (run),
      .raddr   (ra),
      .stored  (mem[ra]),
      .pending (pend_q[ra]),
      .we      (bus.WE),
      .waddr   (bus.WADDR),
      .wdata   (bus.WDATA),
      .rdata   (bus.RDATA[i*DW +: DW]),
      .hazard  (bus.HAZARD[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: one bypassing and one non-bypassing register file driven in lockstep.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic        init_req;
  logic [9:0]  raddr;
  logic        issue_vld;
  logic [4:0]  issue_dst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int checks;
  int failures;

  regfile_sb_if #(.DW(32), .AW(5), .NRD(2)) bus_a ();
  regfile_sb_if #(.DW(32), .AW(5), .NRD(2)) bus_b ();

  assign bus_a.INIT_REQ  = init_req;
  assign bus_a.RADDR     = raddr;
  assign bus_a.ISSUE_VLD = issue_vld;
  assign bus_a.ISSUE_DST = issue_dst;
  assign bus_a.WE        = we;
  assign bus_a.WADDR     = waddr;
  assign bus_a.WDATA     = wdata;

  assign bus_b.INIT_REQ  = init_req;
  assign bus_b.RADDR     = raddr;
  assign bus_b.ISSUE_VLD = issue_vld;
  assign bus_b.ISSUE_DST = issue_dst;
  assign bus_b.WE        = we;
  assign bus_b.WADDR     = waddr;
  assign bus_b.WDATA     = wdata;

  regfile_sb #(.DW(32), .AW(5), .NRD(2), .BYPASS(1)) u_dut_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus_a.slave)
  );

  regfile_sb #(.DW(32), .AW(5), .NRD(2), .BYPASS(0)) u_dut_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus_b.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    init_req  = 1'b0;
    issue_vld = 1'b0;
    issue_dst = '0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
  endtask

  task automatic next();
    @(negedge CLK);
    idle();
  endtask

  // Expects READY low for 32 consecutive cycles starting at the next posedge, then high.
  task automatic sweep_check(input string tag);
    for (int c = 0; c < 32; c++) begin
      #1;
      chk({tag, "_ready_a"}, 64'(bus_a.READY), 64'd0);
      chk({tag, "_ready_b"}, 64'(bus_b.READY), 64'd0);
      @(negedge CLK);
    end
    #1;
    chk({tag, "_ready_a_done"}, 64'(bus_a.READY), 64'd1);
    chk({tag, "_ready_b_done"}, 64'(bus_b.READY), 64'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST_N    = 1'b0;
    raddr    = '0;
    idle();

    // 1) reset and sweep; writes and issues during INIT are dropped
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ready", 64'(bus_a.READY), 64'd0);
    chk("rst_hazard", 64'(bus_a.HAZARD), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    raddr = {5'd6, 5'd5};
    for (int c = 0; c < 32; c++) begin
      if (c == 10) begin
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      end
      if (c == 12) begin
        issue_vld = 1'b1; issue_dst = 5'd6;
      end
      #1;
      chk("init_ready", 64'(bus_a.READY), 64'd0);
      chk("init_rdata", 64'(bus_a.RDATA), 64'd0);
      chk("init_hazard", 64'(bus_a.HAZARD), 64'd0);
      next();
    end
    #1;
    chk("init_ready_done", 64'(bus_a.READY), 64'd1);
    chk("init_r5_dropped", 64'(bus_a.RDATA[31:0]), 64'd0);
    chk("init_r6_no_hazard", 64'(bus_a.HAZARD[1]), 64'd0);

    // 2) plain write/read, r0 guard, non-pending write leaves hazard clear
    we = 1'b1; waddr = 5'd8; wdata = 32'h12345678; raddr = '0;
    next();
    raddr = {5'd8, 5'd8};
    #1;
    chk("r8_port0", 64'(bus_a.RDATA[31:0]), 64'h12345678);
    chk("r8_port1", 64'(bus_a.RDATA[63:32]), 64'h12345678);
    chk("r8_port0_b", 64'(bus_b.RDATA[31:0]), 64'h12345678);
    chk("r8_no_hazard", 64'(bus_a.HAZARD), 64'd0);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = '0;
    #1;
    chk("r0_bypass_blocked", 64'(bus_a.RDATA[31:0]), 64'd0);
    next();
    raddr = '0;
    #1;
    chk("r0_reads_zero", 64'(bus_a.RDATA[31:0]), 64'd0);
    we = 1'b1; waddr = 5'(REGNUM_RA); wdata = 32'h0BADF00D;
    next();
    raddr = {5'(REGNUM_RA), 5'd0};
    #1;
    chk("r31_port1", 64'(bus_a.RDATA[63:32]), 64'h0BADF00D);

    // 3) bypass versus stored value
    we = 1'b1; waddr = 5'd9; wdata = 32'h11111111;
    next();
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; raddr = {5'd0, 5'd9};
    #1;
    chk("bypass_on", 64'(bus_a.RDATA[31:0]), 64'hA5A5A5A5);
    chk("bypass_off", 64'(bus_b.RDATA[31:0]), 64'h11111111);
    next();
    #1;
    chk("r9_after_a", 64'(bus_a.RDATA[31:0]), 64'hA5A5A5A5);
    chk("r9_after_b", 64'(bus_b.RDATA[31:0]), 64'hA5A5A5A5);

    // 4) issue then write-back resolves the hazard
    issue_vld = 1'b1; issue_dst = 5'd10; raddr = {5'd10, 5'd0};
    #1;
    chk("issue_same_cycle", 64'(bus_a.HAZARD[1]), 64'd0);
    next();
    raddr = {5'd10, 5'd0};
    #1;
    chk("r10_hazard_a", 64'(bus_a.HAZARD[1]), 64'd1);
    chk("r10_hazard_b", 64'(bus_b.HAZARD[1]), 64'd1);
    we = 1'b1; waddr = 5'd10; wdata = 32'd7;
    #1;
    chk("r10_wb_hazard_a", 64'(bus_a.HAZARD[1]), 64'd0);
    chk("r10_wb_rdata_a", 64'(bus_a.RDATA[63:32]), 64'd7);
    chk("r10_wb_hazard_b", 64'(bus_b.HAZARD[1]), 64'd1);
    chk("r10_wb_rdata_b", 64'(bus_b.RDATA[63:32]), 64'd0);
    next();
    #1;
    chk("r10_clear_a", 64'(bus_a.HAZARD[1]), 64'd0);
    chk("r10_clear_b", 64'(bus_b.HAZARD[1]), 64'd0);
    chk("r10_value", 64'(bus_a.RDATA[63:32]), 64'd7);

    // 5) set and clear in one cycle: set wins
    issue_vld = 1'b1; issue_dst = 5'd11; we = 1'b1; waddr = 5'd11; wdata = 32'h55;
    next();
    raddr = {5'd0, 5'd11};
    #1;
    chk("r11_set_wins_a", 64'(bus_a.HAZARD[0]), 64'd1);
    chk("r11_set_wins_b", 64'(bus_b.HAZARD[0]), 64'd1);
    chk("r11_data", 64'(bus_a.RDATA[31:0]), 64'h55);
    we = 1'b1; waddr = 5'd11; wdata = 32'h66;
    #1;
    chk("r11_wb_a", 64'(bus_a.HAZARD[0]), 64'd0);
    chk("r11_wb_b", 64'(bus_b.HAZARD[0]), 64'd1);
    next();
    #1;
    chk("r11_clear_a", 64'(bus_a.HAZARD[0]), 64'd0);
    chk("r11_clear_b", 64'(bus_b.HAZARD[0]), 64'd0);
    chk("r11_value", 64'(bus_a.RDATA[31:0]), 64'h66);

    // 6) INIT_REQ clears pending and storage; reset mid-sweep restarts it
    issue_vld = 1'b1; issue_dst = 5'd12;
    next();
    raddr = {5'd12, 5'd8};
    #1;
    chk("r12_pending", 64'(bus_a.HAZARD[1]), 64'd1);
    init_req = 1'b1;
    next();
    raddr = {5'd12, 5'd8};
    sweep_check("initreq");
    chk("initreq_r8_zero", 64'(bus_a.RDATA[31:0]), 64'd0);
    chk("initreq_r12_zero", 64'(bus_a.HAZARD[1]), 64'd0);
    raddr = {5'd10, 5'd9};
    #1;
    chk("initreq_r9_zero", 64'(bus_a.RDATA[31:0]), 64'd0);
    chk("initreq_r10_zero", 64'(bus_b.RDATA[63:32]), 64'd0);

    init_req = 1'b1;
    next();
    for (int c = 0; c < 15; c++) next();
    RST_N = 1'b0;
    #1;
    chk("midsweep_rst_ready", 64'(bus_a.READY), 64'd0);
    next();
    RST_N = 1'b1;
    sweep_check("midsweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
